// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared types and constants for the UART auto-baud calibration slice.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_FALL = 3'd2,
        MEASURE   = 3'd3,
        STOP      = 3'd4,
        ERROR     = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_SHORT    = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_OVF      = 2'd3;

    localparam logic [7:0] SYNC_CHAR = 8'h55;

endpackage

// File: rtl/uart_autobaud_ctrl_if.sv
// Control/status bundle between a host and the auto-baud controller.
interface uart_autobaud_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             rx_en;
    logic [CNT_W-1:0] divisor;
    logic             div_valid;
    logic             busy;
    logic             err;
    logic [1:0]       err_code;

    modport master (output start, input rx_en, divisor, div_valid, busy, err, err_code);
    modport slave  (input start, output rx_en, divisor, div_valid, busy, err, err_code);
endinterface

// File: rtl/uart_autobaud_ctrl_rx_sync_edge.sv
// Two-flop synchroniser for the raw rx line plus a delayed copy for edge detection.
module rx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rise,
    output logic fall
);
    logic meta, sync, dly;

    // Reset to the idle-high level so no false edge appears after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            dly  <= 1'b1;
        end else begin
            meta <= rx;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign rx_s = sync;
    assign rise = sync & ~dly;
    assign fall = ~sync & dly;
endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures a 0x55 sync frame on rx and publishes the bit period.
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 5,
    parameter int MIN_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    uart_autobaud_if.slave bus
);
    localparam logic [2:0] ST_IDLE = IDLE, ST_ARM = ARM, ST_WAIT = WAIT_FALL;
    localparam logic [2:0] ST_MEAS = MEASURE, ST_STOP = STOP, ST_ERR = ERROR;
    localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_BIT);
    localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_DIV);

    logic rx_s, rise, fall, edge_any;
    rx_sync_edge u_sync (.clk(clk), .rst(rst), .rx(rx), .rx_s(rx_s), .rise(rise), .fall(fall));
    assign edge_any = rise | fall;

    logic [2:0]       state;
    logic [CNT_W+2:0] total, total_nxt;
    logic [CNT_W-1:0] seg, seg_nxt, s0, seg_diff, div_new, div_calc;
    logic [CNT_W+3:0] tot_rnd;
    logic [CNT_W:0]   stop_lim;
    logic [2:0]       fall_cnt, fall_nxt;
    logic             first_edge, stop_hi;
    logic [1:0]       pend, meas_code;
    logic             rx_en_q, div_valid_q, busy_q, err_q;
    logic [CNT_W-1:0] div_q;
    logic [1:0]       code_q;

    // seg_nxt/total_nxt include the current cycle, so a segment reads as its full length.
    assign seg_nxt   = seg + CNT_W'(1);
    assign total_nxt = total + (CNT_W+3)'(1);
    assign fall_nxt  = fall_cnt + {2'b00, fall};
    assign seg_diff  = (seg_nxt > s0) ? seg_nxt - s0 : s0 - seg_nxt;
    assign tot_rnd   = {1'b0, total_nxt} + (CNT_W+4)'(4);
    assign div_calc  = CNT_W'(tot_rnd >> 3);
    assign stop_lim  = {1'b0, div_new} + {2'b00, div_new[CNT_W-1:2]};

    // Later assignments override earlier ones, so the highest code wins.
    always_comb begin
        meas_code = ERR_NONE;
        if (edge_any) begin
            if (seg_nxt < MIN_L) meas_code = ERR_SHORT;
            if (!first_edge && seg_diff > (s0 >> 2)) meas_code = ERR_MISMATCH;
        end
        if (seg == '1 || total == '1) meas_code = ERR_OVF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rx_en_q     <= 1'b0;
            div_q       <= DEF_L;
            div_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
            pend        <= ERR_NONE;
            total       <= '0;
            seg         <= '0;
            s0          <= '0;
            div_new     <= '0;
            fall_cnt    <= '0;
            first_edge  <= 1'b0;
            stop_hi     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    err_q       <= 1'b0;
                    code_q      <= ERR_NONE;
                    busy_q      <= 1'b1;
                    rx_en_q     <= 1'b0;
                    div_valid_q <= 1'b0;
                    seg         <= '0;
                    state       <= ST_ARM;
                end
                ST_ARM: begin
                    if (!rx_s)                state <= ST_ARM;
                    else if (seg_nxt >= MIN_L) state <= ST_WAIT;
                    seg <= (rx_s && seg_nxt < MIN_L) ? seg_nxt : '0;
                end
                ST_WAIT: if (fall) begin
                    total      <= '0;
                    seg        <= '0;
                    s0         <= '0;
                    fall_cnt   <= '0;
                    first_edge <= 1'b1;
                    state      <= ST_MEAS;
                end
                ST_MEAS: begin
                    total <= total_nxt;
                    seg   <= seg_nxt;
                    if (meas_code != ERR_NONE) begin
                        pend  <= meas_code;
                        state <= ST_ERR;
                    end else if (edge_any) begin
                        seg        <= '0;
                        first_edge <= 1'b0;
                        fall_cnt   <= fall_nxt;
                        if (first_edge) s0 <= seg_nxt;
                        if (fall_nxt == 3'd4) begin
                            div_new <= div_calc;
                            stop_hi <= 1'b0;
                            state   <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    seg <= seg_nxt;
                    if (!stop_hi) begin
                        if ({1'b0, seg_nxt} > stop_lim) begin
                            pend  <= ERR_MISMATCH;
                            state <= ST_ERR;
                        end else if (rise) begin
                            stop_hi <= 1'b1;
                            seg     <= '0;
                        end
                    end else if (fall) begin
                        pend  <= ERR_MISMATCH;
                        state <= ST_ERR;
                    end else if (seg_nxt >= div_new) begin
                        div_q       <= div_new;
                        div_valid_q <= 1'b1;
                        rx_en_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    err_q       <= 1'b1;
                    code_q      <= pend;
                    busy_q      <= 1'b0;
                    rx_en_q     <= 1'b0;
                    div_q       <= DEF_L;
                    div_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_en     = rx_en_q;
    assign bus.divisor   = div_q;
    assign bus.div_valid = div_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: directed and random sync frames against a segment-level model.
module tb_uart_autobaud_ctrl;
    import uart_pkg::*;

    localparam int DEF_DIV = 5;
    localparam int MIN_BIT = 4;

    typedef int seg_t[9];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic rx2 = 1'b1;
    logic leak = 1'b0;
    logic [7:0] sc = SYNC_CHAR;
    int n_tst = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    uart_autobaud_if #(.CNT_W(16)) bus ();
    uart_autobaud_if #(.CNT_W(8))  bus2 ();

    uart_autobaud_ctrl #(.CNT_W(16), .DEF_DIV(DEF_DIV), .MIN_BIT(MIN_BIT)) dut (
        .clk(clk), .rst(rst), .rx(rx), .bus(bus));
    uart_autobaud_ctrl #(.CNT_W(8), .DEF_DIV(DEF_DIV), .MIN_BIT(MIN_BIT)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .bus(bus2));

    // The receiver must never be enabled while a calibration is running.
    always @(negedge clk) if (bus.busy && bus.rx_en) leak <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tst++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Segment lengths: start bit then data bits b0..b7; the stop bit is held high afterwards.
    function automatic void model(input seg_t l, output int code, output int dv);
        int tot, s0, c, d;
        tot = 0; s0 = 0;
        code = 0; dv = DEF_DIV;
        for (int k = 0; k < 8; k++) begin
            c = 0;
            if (l[k] < MIN_BIT) c = 1;
            d = (l[k] > s0) ? l[k] - s0 : s0 - l[k];
            if (k > 0 && d > s0 / 4) c = 2;
            if (k == 0) s0 = l[k];
            tot += l[k];
            if (c != 0) begin code = c; return; end
        end
        d = (tot + 4) / 8;
        if (l[8] > d + d / 4) begin code = 2; return; end
        dv = d;
    endfunction

    task automatic send_frame(input seg_t l, input bit poke);
        for (int k = 0; k < 9; k++) begin
            rx = (k == 0) ? 1'b0 : sc[k-1];
            for (int c = 0; c < l[k]; c++) begin
                bus.start = poke && k == 3 && c == 1;
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        rx = 1'b1;
    endtask

    task automatic run_cal(input string tag, input seg_t l, input bit poke);
        int code, dv;
        model(l, code, dv);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        chk({tag, "_busy_on"}, bus.busy, 1);
        chk({tag, "_en_off"}, bus.rx_en, 0);
        chk({tag, "_valid_off"}, bus.div_valid, 0);
        repeat (8) @(negedge clk);
        send_frame(l, poke);
        for (int i = 0; i < 600 && bus.busy; i++) @(negedge clk);
        chk({tag, "_done"}, bus.busy, 0);
        chk({tag, "_err"}, bus.err, code != 0);
        chk({tag, "_code"}, bus.err_code, code);
        chk({tag, "_div"}, bus.divisor, dv);
        chk({tag, "_valid"}, bus.div_valid, code == 0);
        chk({tag, "_en"}, bus.rx_en, code == 0);
    endtask

    initial begin
        seg_t l;
        int p, r;
        bus.start = 1'b0;
        bus2.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en", bus.rx_en, 0);
        chk("rst_div", bus.divisor, DEF_DIV);
        chk("rst_valid", bus.div_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_code", bus.err_code, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        l = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
        run_cal("p5", l, 1'b0);
        l = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
        run_cal("p16", l, 1'b0);
        l = '{1, 2, 2, 5, 5, 5, 5, 5, 5};
        run_cal("glitch", l, 1'b0);
        l = '{5, 5, 5, 5, 8, 5, 5, 5, 5};
        run_cal("stretch", l, 1'b0);
        l = '{12, 12, 12, 12, 12, 12, 12, 12, 12};
        run_cal("poke", l, 1'b1);

        // Reset in the middle of a measurement.
        l = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
        run_cal("pre_rst", l, 1'b0);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b0; repeat (7) @(negedge clk);
        rx = 1'b1; repeat (7) @(negedge clk);
        rx = 1'b0; repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", bus.rx_en, 0);
        chk("mid_rst_div", bus.divisor, DEF_DIV);
        chk("mid_rst_valid", bus.div_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_code", bus.err_code, 0);
        rst = 1'b0;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        l = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        run_cal("post_rst", l, 1'b0);

        for (int t = 0; t < 10; t++) begin
            p = int'($urandom_range(5, 20));
            for (int k = 0; k < 9; k++) l[k] = p + int'($urandom_range(0, 2)) - 1;
            r = int'($urandom_range(0, 3));
            if (r == 0) l[$urandom_range(1, 7)] = p + int'($urandom_range(2, p));
            if (r == 1) l[$urandom_range(0, 7)] = int'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) l[8] = 2 * p;
            run_cal("rand", l, 1'b0);
        end

        // Narrow counters with the line stuck low after the start fall.
        @(negedge clk); bus2.start = 1'b1;
        @(negedge clk); bus2.start = 1'b0;
        repeat (8) @(negedge clk);
        rx2 = 1'b0;
        for (int i = 0; i < 400 && !bus2.err; i++) @(negedge clk);
        chk("ovf_err", bus2.err, 1);
        chk("ovf_code", bus2.err_code, ERR_OVF);
        chk("ovf_busy", bus2.busy, 0);
        chk("ovf_div", bus2.divisor, DEF_DIV);
        rx2 = 1'b1;

        chk("en_during_cal", leak, 0);
        $display("[TB] %0d tests run, %0d failed", n_tst, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
Calibration controller for the UART receive path. On request, it measures the 0x55 sync character on the raw rx line and derives the bit period in clock cycles. It publishes that period as the receiver's divisor and gates the receiver enable. The receiver stays disabled during calibration and is enabled only once a valid divisor is published.

Parameters:
CNT_W, 16, width of the measurement counters and of the divisor output
DEF_DIV, 5, divisor value driven out of reset (clk cycles per bit)
MIN_BIT, 4, minimum legal segment length in clk cycles; shorter counts as a glitch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
rx  in  1  raw serial line, asynchronous to clk, idle high
start  in  1  one-cycle pulse that requests calibration
rx_en  out  1  enable to the UART receiver
divisor  out  CNT_W  measured clk cycles per bit
div_valid  out  1  divisor holds a measured (not default) value
busy  out  1  calibration in progress
err  out  1  last calibration failed (sticky until the next start)
err_code  out  2  1 = short segment, 2 = segment mismatch, 3 = overflow/timeout

Behaviour:
- Reset values: rx_en=0, divisor=DEF_DIV, div_valid=0, busy=0, err=0, err_code=0, state=IDLE.
- Synchronisation: rx passes through a 2-flop synchroniser to give rx_s. Edges are detected on rx_s versus its one-cycle-delayed copy. Edge detection adds 3 cycles of latency, which is identical for every edge and cancels out of all measurements.
- Frame: 0x55 is sent LSB first, so the line reads 0,1,0,1,0,1,0,1,0,1.
  - Falling edges occur at bit boundaries 0, 2, 4, 6, 8.
  - The 5th falling edge lies exactly 8 bit times after the 1st.
- IDLE: on start, clear err/err_code, set busy=1, drop rx_en and div_valid, and go to ARM. Leave divisor unchanged. start is ignored in every other state.
- ARM: wait until rx_s=1 for at least MIN_BIT consecutive cycles, then go to WAIT_FALL.
- WAIT_FALL: on a falling edge, clear total, seg, s0 and fall_cnt, then go to MEASURE.
- MEASURE:
  - total and seg increment every cycle.
  - On any edge:
    - If seg < MIN_BIT, raise error code 1.
    - For the first edge (end of the start bit), latch s0 = seg.
    - For later edges, raise error code 2 if |seg - s0| > (s0 >> 2).
    - Reset seg to 0.
  - On the 4th falling edge after the first (fall_cnt == 4), compute divisor_new = (total + 4) >> 3 and go to STOP.
  - If total or seg reaches all-ones, raise error code 3.
- STOP:
  - The line must rise within divisor_new + (divisor_new >> 2) cycles, then stay high for divisor_new cycles.
  - If it does, register divisor := divisor_new, set div_valid=1, rx_en=1 and busy=0, and go to IDLE.
  - A late rise or an early fall raises error code 2.
- ERROR:
  - Entered from any error. Set err=1 and err_code to the code raised, busy=0, rx_en=0.
  - Restore divisor=DEF_DIV and div_valid=0, then go to IDLE.
  - If several errors fire in the same cycle, the highest code wins.
- All outputs are registered and update the cycle after the state transition.
- Reset mid-calibration aborts immediately to the reset values. No partial divisor is ever published.
- Arithmetic:
  - total is CNT_W+3 bits wide, so the >>3 result fits in CNT_W.
  - seg and s0 are CNT_W bits wide.
  - Comparisons are unsigned; |seg - s0| is computed as max - min.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, ARM, WAIT_FALL, MEASURE, STOP, ERROR);
  - error code constants ERR_NONE/SHORT/MISMATCH/OVF;
  - the SYNC_CHAR = 8'h55 constant.
- One sub-module, rx_sync_edge: the 2-flop synchroniser plus registered delay, with outputs rx_s, rise and fall.
- Counters and the FSM stay in uart_autobaud_ctrl.

Test Plan:
- 20 ns clk, start pulse, then 0x55 at 100 ns/bit (5 clk) -> divisor=5, div_valid=1, rx_en=1, busy=0, err=0 about 10 bit times after the first fall.
- 0x55 at 16 clk/bit after a prior 5-clk calibration -> divisor=16. rx_en stays 0 from start until done.
- 0x55 at 5 clk/bit with a 2-clk high glitch inside the start bit -> err=1, err_code=1, divisor=DEF_DIV, div_valid=0.
- 0x55 at 5 clk/bit with data bit 3 stretched to 8 clk -> err_code=2, rx_en=0.
- CNT_W=8 with rx held low after the start fall -> err_code=3 when seg saturates at 255, busy drops the next cycle.
- rst asserted for 1 cycle during MEASURE -> all outputs at reset values on the next cycle. A fresh start then calibrates correctly. A start pulse while busy is ignored, so calibration does not restart.
